// File: rtl/spi_sclk_engine.sv
// SPI SCLK engine: generates a framed SCLK burst with sample/shift strobes for all CPOL/CPHA modes.
// Optional early strobes (pre_sample_stb/pre_shift_stb) are built when SPI_SCLK_PRESTROBE_EN is defined.
module spi_sclk_engine #(
    parameter int SPPR_W  = 3,
    parameter int SPR_W   = 3,
    parameter int FRAME_W = 4,
    localparam int DIV_W  = SPPR_W + (1 << SPR_W) + 1
) (
    input  logic               PCLK,
    input  logic               PRESETn,
    input  logic               start,
    input  logic               abort,
    input  logic               spiswai,
    input  logic               cpol,
    input  logic               cpha,
    input  logic [SPPR_W-1:0]  sppr,
    input  logic [SPR_W-1:0]   spr,
    input  logic [FRAME_W-1:0] nbits,
    output logic               sclk,
    output logic               busy,
    output logic               done,
    output logic               sample_stb,
    output logic               shift_stb,
    output logic [DIV_W-1:0]   baudratedivisor,
    output logic               pre_sample_stb,
    output logic               pre_shift_stb
);

    localparam int EDGE_W = FRAME_W + 2;

    typedef enum logic {IDLE, RUN} state_t;

    state_t              state_q, state_d;
    logic [DIV_W-1:0]    count_q, count_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [EDGE_W-1:0]   edge_q, edge_d;
    logic [EDGE_W-1:0]   total_q, total_d;
    logic                cpha_q, cpha_d;
    logic                sclk_q, sclk_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                sample_q, sample_d;
    logic                shift_q, shift_d;

    logic [DIV_W-1:0]    presc;
    logic [FRAME_W:0]    nbits_eff;
    logic [EDGE_W-1:0]   total_live;
    logic [EDGE_W-1:0]   edge_next;
    logic                edge_last;
    logic                edge_is_sample;
    logic                edge_is_shift;
    logic                at_edge;

    assign presc           = DIV_W'(sppr) + DIV_W'(1);
    assign baudratedivisor = (presc << 1) << spr;

    assign nbits_eff  = (nbits == '0) ? {1'b1, {FRAME_W{1'b0}}} : {1'b0, nbits};
    assign total_live = {nbits_eff, 1'b0};

    // Classification of the upcoming edge k = edge_cnt+1 (shared by real and early strobes).
    assign edge_next      = edge_q + EDGE_W'(1);
    assign edge_last      = (edge_next == total_q);
    assign edge_is_sample = cpha_q ? ~edge_next[0] : edge_next[0];
    assign edge_is_shift  = cpha_q ? edge_next[0] : (~edge_next[0] & ~edge_last);
    assign at_edge        = (count_q == div_q - DIV_W'(1));

`ifdef SPI_SCLK_PRESTROBE_EN
    logic pre_sample_q, pre_sample_d;
    logic pre_shift_q, pre_shift_d;
    logic at_pre;

    assign at_pre = (count_q == div_q - DIV_W'(2));
`endif

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        div_d    = div_q;
        edge_d   = edge_q;
        total_d  = total_q;
        cpha_d   = cpha_q;
        sclk_d   = sclk_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        sample_d = 1'b0;
        shift_d  = 1'b0;
`ifdef SPI_SCLK_PRESTROBE_EN
        pre_sample_d = 1'b0;
        pre_shift_d  = 1'b0;
`endif
        if (abort) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            sclk_d  = cpol;
            count_d = '0;
            edge_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    sclk_d  = cpol;
                    busy_d  = 1'b0;
                    count_d = '0;
                    edge_d  = '0;
                    if (start && !spiswai) begin
                        state_d = RUN;
                        busy_d  = 1'b1;
                        div_d   = baudratedivisor;
                        total_d = total_live;
                        cpha_d  = cpha;
                    end
                end
                RUN: begin
                    // Wait mode simply skips this block: everything holds, no strobes.
                    if (!spiswai) begin
                        if (at_edge) begin
                            count_d  = '0;
                            sclk_d   = ~sclk_q;
                            edge_d   = edge_next;
                            sample_d = edge_is_sample;
                            shift_d  = edge_is_shift;
                            if (edge_last) begin
                                done_d  = 1'b1;
                                busy_d  = 1'b0;
                                edge_d  = '0;
                                state_d = IDLE;
                            end
                        end else begin
                            count_d = count_q + DIV_W'(1);
                        end
`ifdef SPI_SCLK_PRESTROBE_EN
                        if (at_pre) begin
                            pre_sample_d = edge_is_sample;
                            pre_shift_d  = edge_is_shift;
                        end
`endif
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // sclk loads the live cpol during reset so the idle level is correct immediately.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q  <= IDLE;
            count_q  <= '0;
            div_q    <= '0;
            edge_q   <= '0;
            total_q  <= '0;
            cpha_q   <= 1'b0;
            sclk_q   <= cpol;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            sample_q <= 1'b0;
            shift_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            div_q    <= div_d;
            edge_q   <= edge_d;
            total_q  <= total_d;
            cpha_q   <= cpha_d;
            sclk_q   <= sclk_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            sample_q <= sample_d;
            shift_q  <= shift_d;
        end
    end

`ifdef SPI_SCLK_PRESTROBE_EN
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            pre_sample_q <= 1'b0;
            pre_shift_q  <= 1'b0;
        end else begin
            pre_sample_q <= pre_sample_d;
            pre_shift_q  <= pre_shift_d;
        end
    end

    assign pre_sample_stb = pre_sample_q;
    assign pre_shift_stb  = pre_shift_q;
`else
    assign pre_sample_stb = 1'b0;
    assign pre_shift_stb  = 1'b0;
`endif

    assign sclk       = sclk_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign sample_stb = sample_q;
    assign shift_stb  = shift_q;

endmodule

// File: tb/tb_spi_sclk_engine.sv
// Scoreboard bench for spi_sclk_engine: stimulus queues expected strobe/done events per cycle,
// a negedge monitor pops and compares them whenever the cycle arrives or any strobe fires.
module tb_spi_sclk_engine;

    logic        PCLK = 1'b0;
    logic        PRESETn = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        spiswai = 1'b0;
    logic        cpol = 1'b1;
    logic        cpha = 1'b0;
    logic [2:0]  sppr = 3'd0;
    logic [2:0]  spr = 3'd0;
    logic [3:0]  nbits = 4'd0;
    logic        sclk, busy, done, sample_stb, shift_stb;
    logic [11:0] baudratedivisor;
    logic        pre_sample_stb, pre_shift_stb;

    spi_sclk_engine dut (
        .PCLK            (PCLK),
        .PRESETn         (PRESETn),
        .start           (start),
        .abort           (abort),
        .spiswai         (spiswai),
        .cpol            (cpol),
        .cpha            (cpha),
        .sppr            (sppr),
        .spr             (spr),
        .nbits           (nbits),
        .sclk            (sclk),
        .busy            (busy),
        .done            (done),
        .sample_stb      (sample_stb),
        .shift_stb       (shift_stb),
        .baudratedivisor (baudratedivisor),
        .pre_sample_stb  (pre_sample_stb),
        .pre_shift_stb   (pre_shift_stb)
    );

    always #5 PCLK = ~PCLK;

    int cyc = 0;
    always @(posedge PCLK) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        int   cyc;
        logic smp, shf, dn, psmp, pshf, chk_sclk, sclk;
    } rec_t;
    rec_t q[$];

    int cnt_smp = 0, cnt_shf = 0, cnt_done = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @cyc %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // Monitor: compares the expected record for this cycle, or flags an unexpected strobe.
    rec_t       mon_r;
    logic [4:0] mon_act;
    logic [4:0] mon_exp;
    always @(negedge PCLK) begin
        mon_act = {sample_stb, shift_stb, done, pre_sample_stb, pre_shift_stb};
        if (sample_stb) cnt_smp++;
        if (shift_stb)  cnt_shf++;
        if (done)       cnt_done++;
        if (q.size() > 0 && q[0].cyc == cyc) begin
            mon_r   = q.pop_front();
            mon_exp = {mon_r.smp, mon_r.shf, mon_r.dn, mon_r.psmp, mon_r.pshf};
            vectors++;
            if (mon_act !== mon_exp) begin
                miscompares++;
                $display("FAIL strobes @cyc %0d: got smp/shf/done/psmp/pshf=%b, expected %b",
                         cyc, mon_act, mon_exp);
            end
            if (mon_r.chk_sclk) begin
                vectors++;
                if (sclk !== mon_r.sclk) begin
                    miscompares++;
                    $display("FAIL edge_sclk @cyc %0d: got %b, expected %b", cyc, sclk, mon_r.sclk);
                end
            end
        end else if (mon_act != 5'b0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_strobe @cyc %0d: got %b, expected 00000", cyc, mon_act);
        end
    end

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge PCLK);
    endtask

    // Called at a negedge: pulses start for one cycle and returns the first RUN cycle.
    task automatic do_start(output int e);
        start = 1'b1;
        @(negedge PCLK);
        start = 1'b0;
        e = cyc;
    endtask

    // Expected events for edges 1..kmax; edges after fz_k are delayed by fz_len frozen cycles.
    task automatic push_frame(input int e, input int div, input int n, input logic pol,
                              input logic ph, input int kmax, input int fz_k, input int fz_len);
        rec_t r;
        logic odd, last;
        int   t;
        for (int k = 1; k <= kmax; k++) begin
            t    = e + k * div + ((k > fz_k) ? fz_len : 0);
            odd  = (k % 2) == 1;
            last = (k == 2 * n);
            r.cyc = t;
            r.smp = ph ? !odd : odd;
            r.shf = ph ? odd : (!odd && !last);
            r.dn  = last;
            r.psmp = 1'b0;
            r.pshf = 1'b0;
            r.chk_sclk = 1'b1;
            r.sclk = pol ^ odd;
`ifdef SPI_SCLK_PRESTROBE_EN
            if (r.smp || r.shf) begin
                rec_t p;
                p.cyc = t - 1;
                p.smp = 1'b0; p.shf = 1'b0; p.dn = 1'b0;
                p.psmp = r.smp; p.pshf = r.shf;
                p.chk_sclk = 1'b0; p.sclk = 1'b0;
                q.push_back(p);
            end
`endif
            q.push_back(r);
        end
    endtask

    task automatic run_busy(input string name, input int e, input int len);
        int bc = 0;
        while (cyc < e + len) begin
            if (busy) bc++;
            @(negedge PCLK);
        end
        check({name, "_busy_cycles"}, bc, len);
        check({name, "_busy_at_done"}, busy, 0);
    endtask

    task automatic clr_counts();
        cnt_smp = 0; cnt_shf = 0; cnt_done = 0;
    endtask

    typedef struct { logic [2:0] p; logic [2:0] r; logic [11:0] d; } dv_t;
    dv_t dtab[5] = '{'{3'd0, 3'd0, 12'd2}, '{3'd7, 3'd7, 12'd2048}, '{3'd2, 3'd1, 12'd12},
                     '{3'd3, 3'd0, 12'd8}, '{3'd1, 3'd2, 12'd16}};

    initial begin
        int e, e2, x, a;

        // Reset with cpol=1: idle high, everything quiet.
        repeat (3) @(negedge PCLK);
        check("rst_sclk", sclk, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_strobes", {sample_stb, shift_stb, pre_sample_stb, pre_shift_stb}, 0);
        PRESETn = 1'b1;
        @(negedge PCLK);
        cpol = 1'b0;
        #1 check("idle_sclk_lag", sclk, 1);
        @(negedge PCLK);
        check("idle_sclk_follow", sclk, 0);

        foreach (dtab[i]) begin
            sppr = dtab[i].p;
            spr  = dtab[i].r;
            #1 check($sformatf("divisor_%0d_%0d", dtab[i].p, dtab[i].r), baudratedivisor, dtab[i].d);
        end

        // Mode 0, div 2, 8 bits.
        sppr = 3'd0; spr = 3'd0; cpol = 1'b0; cpha = 1'b0; nbits = 4'd8;
        @(negedge PCLK);
        clr_counts();
        do_start(e);
        push_frame(e, 2, 8, 1'b0, 1'b0, 16, 99, 0);
        run_busy("m0", e, 32);
        @(negedge PCLK);
        check("m0_samples", cnt_smp, 8);
        check("m0_shifts", cnt_shf, 7);
        check("m0_dones", cnt_done, 1);

        // Mode 3, div 12, 16 bits.
        sppr = 3'd2; spr = 3'd1; cpol = 1'b1; cpha = 1'b1; nbits = 4'd0;
        @(negedge PCLK);
        check("m3_idle_sclk", sclk, 1);
        clr_counts();
        do_start(e);
        push_frame(e, 12, 16, 1'b1, 1'b1, 32, 99, 0);
        run_busy("m3", e, 384);
        check("m3_end_sclk", sclk, 1);
        @(negedge PCLK);
        check("m3_shifts", cnt_shf, 16);
        check("m3_samples", cnt_smp, 16);

        // Wait-mode freeze at edge 5 for 20 cycles.
        sppr = 3'd0; spr = 3'd0; cpol = 1'b0; cpha = 1'b0; nbits = 4'd4;
        @(negedge PCLK);
        clr_counts();
        do_start(e);
        x = e + 10;
        push_frame(e, 2, 4, 1'b0, 1'b0, 8, 5, 20);
        wait_until(x);
        spiswai = 1'b1;
        wait_until(x + 10);
        check("freeze_sclk", sclk, 1);
        check("freeze_busy", busy, 1);
        wait_until(x + 20);
        spiswai = 1'b0;
        wait_until(x + 27);
        check("freeze_samples", cnt_smp, 4);
        check("freeze_shifts", cnt_shf, 3);

        // start during wait mode is dropped.
        spiswai = 1'b1; start = 1'b1;
        repeat (2) @(negedge PCLK);
        spiswai = 1'b0; start = 1'b0;
        check("swai_start_ignored", busy, 0);
        @(negedge PCLK);
        check("swai_start_not_queued", busy, 0);

        // Abort at edge 3 together with start.
        sppr = 3'd1; spr = 3'd0; nbits = 4'd8;
        @(negedge PCLK);
        do_start(e);
        push_frame(e, 4, 8, 1'b0, 1'b0, 3, 99, 0);
        a = e + 12;
        wait_until(a);
        abort = 1'b1; start = 1'b1;
        @(negedge PCLK);
        abort = 1'b0; start = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_sclk", sclk, 0);
        check("abort_done", done, 0);
        @(negedge PCLK);
        check("abort_stays_idle", busy, 0);
        do_start(e2);
        push_frame(e2, 4, 8, 1'b0, 1'b0, 16, 99, 0);
        run_busy("post_abort", e2, 64);

        // Config changes mid-frame take effect only on the next start.
        sppr = 3'd0; spr = 3'd1; cpol = 1'b0; cpha = 1'b0; nbits = 4'd2;
        @(negedge PCLK);
        do_start(e);
        push_frame(e, 4, 2, 1'b0, 1'b0, 4, 99, 0);
        repeat (2) @(negedge PCLK);
        sppr = 3'd3; spr = 3'd2; cpol = 1'b1; nbits = 4'd1;
        #1 check("live_divisor", baudratedivisor, 32);
        wait_until(e + 16);
        check("cfg_done_busy", busy, 0);
        @(negedge PCLK);
        check("cfg_idle_new_cpol", sclk, 1);
        do_start(e);
        push_frame(e, 32, 1, 1'b1, 1'b0, 2, 99, 0);
        run_busy("new_cfg", e, 64);
        check("new_cfg_end_sclk", sclk, 1);

        // Divisor 8, mode 1: early strobes (when built) lead by one cycle.
        sppr = 3'd3; spr = 3'd0; cpol = 1'b0; cpha = 1'b1; nbits = 4'd3;
        @(negedge PCLK);
        do_start(e);
        push_frame(e, 8, 3, 1'b0, 1'b1, 6, 99, 0);
        run_busy("div8", e, 48);

        // start held through completion: one idle cycle, then a new frame.
        sppr = 3'd0; spr = 3'd0; cpha = 1'b0; cpol = 1'b0; nbits = 4'd1;
        @(negedge PCLK);
        start = 1'b1;
        @(negedge PCLK);
        e = cyc;
        push_frame(e, 2, 1, 1'b0, 1'b0, 2, 99, 0);
        push_frame(e + 5, 2, 1, 1'b0, 1'b0, 2, 99, 0);
        wait_until(e + 4);
        check("held_gap_busy", busy, 0);
        @(negedge PCLK);
        start = 1'b0;
        check("held_restart_busy", busy, 1);
        wait_until(e + 10);

        // Asynchronous reset mid-frame.
        sppr = 3'd1; spr = 3'd0; nbits = 4'd4;
        @(negedge PCLK);
        do_start(e);
        push_frame(e, 4, 4, 1'b0, 1'b0, 1, 99, 0);
        wait_until(e + 5);
        check("pre_rst_sclk", sclk, 1);
        #2 PRESETn = 1'b0;
        #1;
        check("async_rst_sclk", sclk, 0);
        check("async_rst_busy", busy, 0);
        @(negedge PCLK);
        PRESETn = 1'b1;
        repeat (12) @(negedge PCLK);
        check("async_rst_stays_idle", busy, 0);

        check("queue_drained", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/spi_sclk_engine.md
Name: spi_sclk_engine

Overview:
- Parametrised successor to the SPI baud-rate generator. It generates SCLK from PCLK for a complete framed transfer of N bits, with a start/busy/done handshake.
- Emits per-edge sample and shift strobes for all four CPOL/CPHA modes, plus wait-mode freeze and abort.
- Sits between the APB register slave (config, start) and the shift register/MISO sampler.

Parameters:
- SPPR_W, 3, width of prescaler select; prescale factor = sppr+1.
- SPR_W, 3, width of rate select; factor = 2^(spr+1).
- FRAME_W, 4, width of bit-count field; nbits=0 encodes 2^FRAME_W bits.
- DIV_W (localparam), SPPR_W+(1<<SPR_W)+1, divisor/counter width (12 at defaults).

Ports:
- PCLK  in  1  system clock.
- PRESETn  in  1  async active-low reset.
- start  in  1  request a transfer; sampled in IDLE only.
- abort  in  1  synchronous cancel of the current transfer.
- spiswai  in  1  wait mode; freezes a running transfer.
- cpol  in  1  SCLK idle level.
- cpha  in  1  0: sample on leading edges; 1: shift on leading edges.
- sppr  in  SPPR_W  prescaler select.
- spr  in  SPR_W  rate select.
- nbits  in  FRAME_W  bits per frame; 0 means 2^FRAME_W.
- sclk  out  1  serial clock.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle pulse at normal completion.
- sample_stb  out  1  one-cycle pulse: sample MISO now.
- shift_stb  out  1  one-cycle pulse: drive next MOSI bit now.
- baudratedivisor  out  DIV_W  live (sppr+1)<<(spr+1), combinational from the inputs.
- pre_sample_stb  out  1  early sample strobe (optional feature).
- pre_shift_stb  out  1  early shift strobe (optional feature).

Behaviour:
- Reset values: sclk=cpol (async), busy=0, done=0, all strobes 0, count=0, edge_cnt=0, state=IDLE.
- baudratedivisor is computed at full DIV_W width with no truncation. Minimum value is 2; maximum is 2048 at defaults.
- The FSM has two states, IDLE and RUN.
- IDLE:
  - sclk follows cpol combinationally-registered, updating one cycle after a cpol change.
  - If start=1 and spiswai=0 and abort=0: latch cpol, cpha, divisor and nbits; clear count and edge_cnt; go to RUN. busy=1 from the next cycle.
  - start with spiswai=1 is ignored and not queued.
- RUN, counting:
  - While spiswai=0, count increments each PCLK.
  - When count==div_latched-1: count<=0, sclk<=~sclk, edge_cnt<=edge_cnt+1.
  - SCLK period = 2*div PCLK cycles. The first edge occurs div cycles after entering RUN.
- RUN, strobes:
  - Strobes are registered and asserted in the same cycle sclk shows its new value. Edge index is k=1..2N.
  - cpha=0: sample_stb on odd k; shift_stb on even k with k<2N. The first bit is preloaded by the shifter on start.
  - cpha=1: shift_stb on odd k; sample_stb on even k.
  - sample_stb and shift_stb are never asserted together.
- RUN, completion: on edge 2N, done=1 for one cycle, busy=0 in that same cycle, go to IDLE. sclk is already back at cpol after the even number of toggles.
- spiswai=1 in RUN: count, sclk and edge_cnt hold; no strobes. Counting resumes exactly where it stopped when spiswai returns to 0.
- abort=1 (any state):
  - Next cycle: IDLE, busy=0, sclk=cpol, count=0, no done, no strobes.
  - abort has priority over start, spiswai and edge events in the same cycle.
- Config inputs changing during RUN have no effect; latched copies are used. baudratedivisor still tracks the live inputs.
- start held high through completion: one IDLE cycle (busy=0, done=1), then a new transfer starts.
- Async reset mid-transfer returns all outputs to their reset values immediately.

Optional Feature:
- Macro: SPI_SCLK_PRESTROBE_EN.
- Defined:
  - pre_sample_stb and pre_shift_stb pulse exactly one PCLK before the corresponding sample_stb/shift_stb, registered at count==div-2.
  - With div=2 they coincide with the cycle following the previous edge.
  - Same suppression rules (spiswai, abort) apply.
- Undefined: both ports are tied to 0 and the extra compare logic is absent.

Test Plan:
- sppr=0, spr=0, cpol=0, cpha=0, nbits=8, start pulse:
  - SCLK period 4 PCLK, first rise 2 cycles after RUN, 16 edges.
  - 8 sample_stb on rises, 7 shift_stb on falls.
  - done once, busy high for 32 cycles.
- sppr=2, spr=1, cpol=1, cpha=1, nbits=0:
  - divisor=12, SCLK idles high, 32 edges.
  - 16 shift_stb on falls, 16 sample_stb on rises.
  - Ends with sclk=1, done pulse.
- Mid-frame spiswai=1 for 20 cycles at edge 5, mode 0, nbits=4:
  - sclk and count frozen, no strobes.
  - After release, remaining 3 edges keep exact 2-cycle spacing.
  - Total strobe counts unchanged.
- abort asserted at edge 3 in the same cycle as start re-asserted:
  - Next cycle busy=0, sclk=cpol, no done.
  - A new start two cycles later runs a full frame.
- Change sppr/spr/cpol during RUN:
  - SCLK timing unchanged.
  - baudratedivisor output updates immediately.
  - New settings apply on the next start.
- With SPI_SCLK_PRESTROBE_EN defined, div=8:
  - Each pre_* strobe precedes its strobe by exactly 1 cycle.
  - Undefined build: pre_* stay 0.
